// File: rtl/grf_pkg.sv
// -----------------------------------------------------------------------------
// grf_pkg
// Shared constants for the multi-port register file with pending-write
// scoreboard: default widths, architectural register numbers, reset values of
// the global/stack pointers, and the helper that locates a read port's slice
// inside the flattened port vectors.
// -----------------------------------------------------------------------------
package grf_pkg;

    localparam int GRF_DATA_W = 32;
    localparam int GRF_ADDR_W = 5;
    localparam int GRF_NUM_RD = 2;
    localparam int GRF_CNT_W  = 2;

    localparam int REG_ZERO = 0;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;

    localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;

    // LSB of port k inside a flattened vector of w-bit fields.
    function automatic int port_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/grf_sb_cnt.sv
// -----------------------------------------------------------------------------
// grf_sb_cnt
// Saturating up/down counter tracking outstanding writes to one register.
// One issue can increment and up to two write ports can decrement in the same
// cycle; the net change is applied at once. A net result below zero clamps to
// zero, above the maximum saturates, and either case raises err for that cycle.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous active-low reset
//   i_inc   in   an instruction targeting this register was issued
//   i_dec0  in   write port 0 writes this register
//   i_dec1  in   write port 1 writes this register
//   o_cnt   out  current (registered) pending count
//   o_err   out  this cycle's update over- or underflows (combinational pulse)
// -----------------------------------------------------------------------------
module grf_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec0,
    input  logic             i_dec1,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_err
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W+1:0] w_sum;
    logic [CNT_W-1:0] w_next;
    logic             w_err;

    // Two guard bits: the top bit flags a negative sum, bit CNT_W an overflow.
    assign w_sum = {2'b00, r_cnt}
                 + {{(CNT_W+1){1'b0}}, i_inc}
                 - {{(CNT_W+1){1'b0}}, i_dec0}
                 - {{(CNT_W+1){1'b0}}, i_dec1};

    // Clamp the net result into the counter range and flag any clamping.
    always_comb begin
        w_next = r_cnt;
        w_err  = 1'b0;
        if (w_sum[CNT_W+1]) begin
            w_next = '0;
            w_err  = 1'b1;
        end else if (w_sum[CNT_W]) begin
            w_next = '1;
            w_err  = 1'b1;
        end else begin
            w_next = w_sum[CNT_W-1:0];
            w_err  = 1'b0;
        end
    end

    // Pending-count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt = r_cnt;
    assign o_err = w_err;

endmodule

// File: rtl/grf_mp_sb.sv
// -----------------------------------------------------------------------------
// grf_mp_sb
// Multi-port general register file with write-through bypass and a per-register
// pending-write scoreboard used by decode for hazard/stall detection.
// W0 is the late (M-stage) write port, W1 the writeback port; when both hit the
// same register W1 is the younger result and wins, both in storage and bypass.
// Register 0 reads as zero, ignores writes and is never tracked.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   rd_addr    in   NUM_RD read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    out  NUM_RD read data, combinational with bypass
//   rd_busy    out  per read port: register still has writes outstanding
//                   after this cycle's writes land
//   we0/wa0/wd0 in  write port 0
//   we1/wa1/wd1 in  write port 1
//   iss_valid  in   an issued instruction will write iss_addr
//   iss_addr   in   destination of the issued instruction
//   busy_vec   out  bit i = register i has a nonzero pending count
//   sb_err     out  sticky counter over/underflow flag, cleared by reset only
// -----------------------------------------------------------------------------
module grf_mp_sb
    import grf_pkg::*;
#(
    parameter int                DATA_W  = GRF_DATA_W,
    parameter int                ADDR_W  = GRF_ADDR_W,
    parameter int                NUM_RD  = GRF_NUM_RD,
    parameter int                CNT_W   = GRF_CNT_W,
    parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(GP_INIT_DEF),
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic                     sb_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  w_cnt  [DEPTH];
    logic [DEPTH-1:0]  w_err;
    logic              r_sb_err;

    // Register storage; W1 overrides W0 on an address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == REG_GP) begin
                    r_regs[i] <= GP_INIT;
                end else if (i == REG_SP) begin
                    r_regs[i] <= SP_INIT;
                end else begin
                    r_regs[i] <= '0;
                end
            end
        end else begin
            r_regs[0] <= '0;
            for (int i = 1; i < DEPTH; i++) begin
                if (we1 && (wa1 == ADDR_W'(i))) begin
                    r_regs[i] <= wd1;
                end else if (we0 && (wa0 == ADDR_W'(i))) begin
                    r_regs[i] <= wd0;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // r0 has no counter: it is permanently idle.
    assign w_cnt[0]    = '0;
    assign w_err[0]    = 1'b0;
    assign busy_vec[0] = 1'b0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_cnt
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);

        grf_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .i_inc  (iss_valid && (iss_addr == IDX)),
            .i_dec0 (we0 && (wa0 == IDX)),
            .i_dec1 (we1 && (wa1 == IDX)),
            .o_cnt  (w_cnt[i]),
            .o_err  (w_err[i])
        );

        assign busy_vec[i] = |w_cnt[i];
    end

    // Sticky scoreboard error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sb_err <= 1'b0;
        end else begin
            r_sb_err <= r_sb_err | (|w_err);
        end
    end

    assign sb_err = r_sb_err;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int A_LSB = port_lsb(k, ADDR_W);
        localparam int D_LSB = port_lsb(k, DATA_W);

        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_hit0;
        logic              w_hit1;
        logic [CNT_W+1:0]  w_left;
        logic              w_busy;

        assign w_addr = rd_addr[A_LSB +: ADDR_W];
        assign w_hit0 = we0 && (wa0 == w_addr);
        assign w_hit1 = we1 && (wa1 == w_addr);

        // Bypass mux: r0 forced to zero, then W1, then W0, then storage.
        always_comb begin
            w_data = '0;
            if (w_addr == ADDR_ZERO) begin
                w_data = '0;
            end else if (w_hit1) begin
                w_data = wd1;
            end else if (w_hit0) begin
                w_data = wd0;
            end else begin
                w_data = r_regs[w_addr];
            end
        end

        // Busy after this cycle's writes retire; an issue this cycle only
        // shows up once the counter has registered it.
        always_comb begin
            w_left = {2'b00, w_cnt[w_addr]}
                   - {{(CNT_W+1){1'b0}}, w_hit0}
                   - {{(CNT_W+1){1'b0}}, w_hit1};
            w_busy = 1'b0;
            if (w_addr == ADDR_ZERO) begin
                w_busy = 1'b0;
            end else begin
                w_busy = (w_left != '0);
            end
        end

        assign rd_data[D_LSB +: DATA_W] = w_data;
        assign rd_busy[k]               = w_busy;
    end

endmodule

// File: tb/tb_grf_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_grf_mp_sb
// Directed bench for grf_mp_sb. The stimulus process drives inputs and pushes
// hand-computed expectations into a queue; a monitor process pops and compares
// them each time the stimulus signals that outputs are presented.
// -----------------------------------------------------------------------------
module tb_grf_mp_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int CW    = 2;
    localparam int DEPTH = 32;

    localparam int K_RD   = 0;
    localparam int K_RB   = 1;
    localparam int K_BV   = 2;
    localparam int K_BVA  = 3;
    localparam int K_ERR  = 4;

    logic              clk;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic [DEPTH-1:0]  busy_vec;
    logic              sb_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;

    grf_mp_sb #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_RD  (NR),
        .CNT_W   (CW),
        .GP_INIT (32'h0000_1800),
        .SP_INIT (32'h0000_2ffc)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy_vec  (busy_vec),
        .sb_err    (sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] actual(input int kind, input int idx);
        case (kind)
            K_RD:    return rd_data[idx*DW +: DW];
            K_RB:    return {31'b0, rd_busy[idx]};
            K_BV:    return {31'b0, busy_vec[idx]};
            K_BVA:   return busy_vec;
            K_ERR:   return {31'b0, sb_err};
            default: return 32'hDEAD_DEAD;
        endcase
    endfunction

    // Monitor: drain the expectation queue whenever outputs are presented.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = actual(e.kind, e.idx);
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input string nm, input int kind, input int idx, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_valid = 1'b1;
        iss_addr  = a;
    endtask

    // Let combinational outputs settle, then hand them to the monitor.
    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle();
        rd(5'd0, 5'd0);
        #12;
        reset = 1'b1;
        tick();

        // Reset values
        idle(); rd(5'd0, 5'd28);
        push("rst_r0", K_RD, 0, 32'h0);
        push("rst_r28", K_RD, 1, 32'h1800);
        push("rst_busy_vec", K_BVA, 0, 32'h0);
        push("rst_sb_err", K_ERR, 0, 32'h0);
        sample();
        rd(5'd29, 5'd5);
        push("rst_r29", K_RD, 0, 32'h2ffc);
        push("rst_r5", K_RD, 1, 32'h0);
        sample();

        // Bypass / priority (r3 issued twice so the double write is legal)
        idle(); issue(5'd3); tick();
        idle(); issue(5'd3);
        push("r3_busy_after_iss", K_BV, 3, 32'h1);
        sample(); tick();
        idle(); rd(5'd3, 5'd3);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000_AAAA;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000_5555;
        push("bypass_w1_wins_p0", K_RD, 0, 32'h5555);
        push("bypass_w1_wins_p1", K_RD, 1, 32'h5555);
        push("r3_rd_busy_last_writes", K_RB, 0, 32'h0);
        sample(); tick();
        idle(); rd(5'd3, 5'd0);
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h0000_FFFF;
        push("r3_stored_w1", K_RD, 0, 32'h5555);
        push("r0_bypass_zero", K_RD, 1, 32'h0);
        push("r3_not_busy", K_BV, 3, 32'h0);
        push("no_err_balanced", K_ERR, 0, 32'h0);
        sample(); tick();
        idle(); rd(5'd3, 5'd0);
        push("r0_write_ignored", K_RD, 1, 32'h0);
        push("r0_write_no_err", K_ERR, 0, 32'h0);
        sample();

        // Scoreboard on r7
        idle(); issue(5'd7); tick();
        idle(); issue(5'd7);
        push("r7_busy_cnt1", K_BV, 7, 32'h1);
        sample(); tick();
        idle(); rd(5'd7, 5'd0);
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_0077;
        push("r7_rd_busy_cnt2_w1", K_RB, 0, 32'h1);
        push("r7_bypass_w1", K_RD, 0, 32'h77);
        sample(); tick();
        idle(); rd(5'd7, 5'd0);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_1234;
        push("r7_still_busy", K_BV, 7, 32'h1);
        push("r7_rd_busy_final_write", K_RB, 0, 32'h0);
        push("r7_bypass_w0", K_RD, 0, 32'h1234);
        sample(); tick();
        idle(); rd(5'd7, 5'd0);
        push("r7_cleared", K_BV, 7, 32'h0);
        push("r7_stored", K_RD, 0, 32'h1234);
        sample();

        // Simultaneous issue and writeback on r4
        idle(); issue(5'd4); tick();
        idle(); issue(5'd4); rd(5'd0, 5'd4);
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_0044;
        push("r4_busy_cnt1", K_BV, 4, 32'h1);
        push("r4_rd_busy_excl_iss", K_RB, 1, 32'h0);
        push("r4_bypass", K_RD, 1, 32'h44);
        sample(); tick();
        idle(); rd(5'd0, 5'd4);
        push("r4_net_zero_busy", K_BV, 4, 32'h1);
        push("r4_rd_busy_cnt1", K_RB, 1, 32'h1);
        push("r4_no_err", K_ERR, 0, 32'h0);
        sample();

        // Saturation on r10
        for (int i = 0; i < 3; i++) begin
            idle(); issue(5'd10); tick();
        end
        idle(); issue(5'd10);
        push("r10_no_err_at_max", K_ERR, 0, 32'h0);
        push("r10_busy", K_BV, 10, 32'h1);
        sample(); tick();
        idle(); rd(5'd10, 5'd0);
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h0000_0010;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h0000_0011;
        push("sat_err_set", K_ERR, 0, 32'h1);
        push("sat_still_busy", K_BV, 10, 32'h1);
        push("sat_cnt3_minus2", K_RB, 0, 32'h1);
        sample(); tick();
        idle(); rd(5'd10, 5'd0);
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h0000_0012;
        push("sat_cnt1_minus1", K_RB, 0, 32'h0);
        sample(); tick();
        idle(); rd(5'd10, 5'd0);
        push("sat_cleared", K_BV, 10, 32'h0);
        push("sat_err_sticky", K_ERR, 0, 32'h1);
        sample();

        // Async reset mid-cycle with r7 pending twice and r3 = 0x5555
        idle(); issue(5'd7); tick();
        idle(); issue(5'd7); tick();
        idle(); rd(5'd3, 5'd28);
        push("pre_rst_r7_busy", K_BV, 7, 32'h1);
        push("pre_rst_r3", K_RD, 0, 32'h5555);
        sample();
        reset = 1'b0;
        push("arst_busy_vec", K_BVA, 0, 32'h0);
        push("arst_r3", K_RD, 0, 32'h0);
        push("arst_r28", K_RD, 1, 32'h1800);
        push("arst_sb_err", K_ERR, 0, 32'h0);
        sample();
        reset = 1'b1;
        tick();
        idle(); rd(5'd29, 5'd7);
        push("post_rst_r29", K_RD, 0, 32'h2ffc);
        push("post_rst_r7", K_RD, 1, 32'h0);
        push("post_rst_busy_vec", K_BVA, 0, 32'h0);
        sample();

        // Underflow on r9
        idle(); rd(5'd9, 5'd0);
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0099;
        push("uf_bypass", K_RD, 0, 32'h99);
        push("uf_err_before_edge", K_ERR, 0, 32'h0);
        sample(); tick();
        idle(); rd(5'd9, 5'd0);
        push("uf_err_set", K_ERR, 0, 32'h1);
        push("uf_clamp_zero", K_BV, 9, 32'h0);
        push("uf_write_stored", K_RD, 0, 32'h99);
        sample(); tick();
        idle();
        push("uf_err_sticky", K_ERR, 0, 32'h1);
        sample();

        #5;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
